// File: rtl/dlsc_demosaic_vng6_pkg.sv
// Shared constants for the VNG6 demosaic engine: FSM encoding, default phase
// count, phase index width and the pipeline tag record.
package dlsc_demosaic_vng6_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int VNG6_STATES = 12;
  localparam int VNG6_ST_W   = 4;

  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

endpackage

// File: rtl/dlsc_demosaic_vng6_seq_if.sv
// Token handshake, phase index/strobe and result handshake of the VNG6 sequencer.
interface dlsc_demosaic_vng6_seq_if;
  import dlsc_demosaic_vng6_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic                 clk_en;
  logic [VNG6_ST_W-1:0] st;
  logic                 st_first;
  logic                 st_last;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;

  modport master (
    input  in_valid, in_last, out_ready,
    output in_ready, clk_en, st, st_first, st_last, out_valid, out_last
  );

  modport slave (
    output in_valid, in_last, out_ready,
    input  in_ready, clk_en, st, st_first, st_last, out_valid, out_last
  );
endinterface

// File: rtl/dlsc_demosaic_vng6_tagpipe.sv
// PIPE-deep valid/last shift register that tracks tokens through the engine;
// advances only on the engine strobe, output entry cleared when consumed.
module dlsc_demosaic_vng6_tagpipe
  import dlsc_demosaic_vng6_pkg::*;
#(
  parameter int PIPE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  tag_t tag_i,
  input  logic consume_i,
  output tag_t tag_o,
  output logic any_vld_o
);

  tag_t [PIPE-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = pipe_q;
    if (en_i) begin
      pipe_d[0] = tag_i;
      for (int i = 1; i < PIPE; i++) pipe_d[i] = pipe_q[i-1];
    end else if (consume_i) begin
      pipe_d[PIPE-1] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  always_comb begin
    any_vld_o = 1'b0;
    for (int i = 0; i < PIPE; i++) any_vld_o = any_vld_o | pipe_q[i].vld;
  end

  assign tag_o = pipe_q[PIPE-1];

endmodule

// File: rtl/dlsc_demosaic_vng6_seq.sv
// VNG6 phase sequencer: steps st once per accepted token, tracks results through
// the engine and freezes everything on output backpressure.
// Optional stall counter output under DLSC_DEMOSAIC_VNG6_SEQ_PERF_EN.
module dlsc_demosaic_vng6_seq
  import dlsc_demosaic_vng6_pkg::*;
#(
  parameter int STATES = VNG6_STATES,
  parameter int PIPE   = 4
) (
  input  logic clk,
  input  logic rst_n,
  dlsc_demosaic_vng6_seq_if.master sif
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [VNG6_ST_W-1:0] ST_MAX = VNG6_ST_W'(STATES - 1);

  logic [0:0]           state_q, state_d;
  logic [VNG6_ST_W-1:0] st_q, st_d;
  logic                 last_q, last_d;

  logic running, final_ph, stall, clk_en, accept, insert, any_vld;
  tag_t tag_in, tag_out;

  assign running  = (state_q == ST_RUN);
  assign final_ph = running && (st_q == ST_MAX);
  assign stall    = tag_out.vld && !sif.out_ready;
  assign clk_en   = !stall && (running || any_vld);
  // Tokens are only taken while idle or on the final phase, so back-to-back runs have no bubble.
  assign sif.in_ready = !stall && (!running || final_ph);
  assign accept   = sif.in_valid && sif.in_ready;
  assign insert   = final_ph && clk_en;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_RUN;
        st_d    = '0;
        last_d  = sif.in_last;
      end
      ST_RUN: if (clk_en) begin
        if (st_q == ST_MAX) begin
          st_d = '0;
          if (accept) last_d  = sif.in_last;
          else        state_d = ST_IDLE;
        end else begin
          st_d = st_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      st_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      last_q  <= last_d;
    end
  end

  assign tag_in.vld  = insert;
  assign tag_in.last = insert && last_q;

  dlsc_demosaic_vng6_tagpipe #(.PIPE(PIPE)) u_tagpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (clk_en),
    .tag_i     (tag_in),
    .consume_i (tag_out.vld && sif.out_ready),
    .tag_o     (tag_out),
    .any_vld_o (any_vld)
  );

  assign sif.clk_en    = clk_en;
  assign sif.st        = st_q;
  assign sif.st_first  = running && (st_q == '0);
  assign sif.st_last   = final_ph;
  assign sif.out_valid = tag_out.vld;
  assign sif.out_last  = tag_out.last;

`ifdef DLSC_DEMOSAIC_VNG6_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (stall && (running || any_vld) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dlsc_demosaic_vng6_seq.sv
// Directed bench for the VNG6 sequencer: u0 uses STATES=12/PIPE=4, u1 uses
// STATES=8/PIPE=16 so a result can land on the final phase with two tags in flight.
module tb_dlsc_demosaic_vng6_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dlsc_demosaic_vng6_seq_if b0 ();
  dlsc_demosaic_vng6_seq_if b1 ();

`ifdef DLSC_DEMOSAIC_VNG6_SEQ_PERF_EN
  logic [31:0] sc0, sc1;
`endif

  dlsc_demosaic_vng6_seq #(.STATES(12), .PIPE(4)) u0 (
    .clk(clk), .rst_n(rst_n), .sif(b0)
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_PERF_EN
    , .stall_cnt(sc0)
`endif
  );

  dlsc_demosaic_vng6_seq #(.STATES(8), .PIPE(16)) u1 (
    .clk(clk), .rst_n(rst_n), .sif(b1)
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_PERF_EN
    , .stall_cnt(sc1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b0.in_valid = 1'b0; b0.in_last = 1'b0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", b0.out_valid); end
    checks++; if (b0.out_last  !== 1'b0) begin errors++; $display("FAIL reset out_last got %b exp 0", b0.out_last); end
    checks++; if (b0.st_first  !== 1'b0) begin errors++; $display("FAIL reset st_first got %b exp 0", b0.st_first); end
    checks++; if (b0.st_last   !== 1'b0) begin errors++; $display("FAIL reset st_last got %b exp 0", b0.st_last); end
    checks++; if (b0.clk_en    !== 1'b0) begin errors++; $display("FAIL reset clk_en got %b exp 0", b0.clk_en); end
    checks++; if (b0.in_ready  !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", b0.in_ready); end
    checks++; if (b0.st !== 4'd0) begin errors++; $display("FAIL reset st got %0d exp 0", b0.st); end
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_PERF_EN
    checks++; if (sc0 !== 32'd0) begin errors++; $display("FAIL reset stall_cnt got %0d exp 0", sc0); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  // Accept at cycle 0; phases on cycles 1..12; single result at cycle 16.
  task automatic test_single();
    b0.in_valid = 1'b1; b0.in_last = 1'b0;
    #1;
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL single accept in_ready got %b exp 1", b0.in_ready); end
    tick();
    b0.in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      logic [3:0] e_st;
      e_st = (c <= 12) ? 4'(c - 1) : 4'd0;
      #1;
      checks++; if (b0.st !== e_st) begin errors++; $display("FAIL single st c=%0d got %0d exp %0d", c, b0.st, e_st); end
      checks++; if (b0.st_first !== (c == 1)) begin errors++; $display("FAIL single st_first c=%0d got %b", c, b0.st_first); end
      checks++; if (b0.st_last !== (c == 12)) begin errors++; $display("FAIL single st_last c=%0d got %b", c, b0.st_last); end
      checks++; if (b0.out_valid !== (c == 16)) begin errors++; $display("FAIL single out_valid c=%0d got %b", c, b0.out_valid); end
      tick();
    end
  endtask

  // Three tokens with in_valid held; last flag on the third.
  task automatic test_back_to_back();
    int acc = 0;
    for (int c = 0; c <= 44; c++) begin
      b0.in_valid = (acc < 3);
      b0.in_last  = (acc == 2);
      #1;
      checks++; if (b0.in_ready !== ((c % 12 == 0) || (c > 36))) begin errors++; $display("FAIL b2b in_ready c=%0d got %b", c, b0.in_ready); end
      checks++; if (b0.out_valid !== (c == 16 || c == 28 || c == 40)) begin errors++; $display("FAIL b2b out_valid c=%0d got %b", c, b0.out_valid); end
      checks++; if (b0.out_last !== (c == 40)) begin errors++; $display("FAIL b2b out_last c=%0d got %b", c, b0.out_last); end
      if (b0.in_valid && b0.in_ready) acc++;
      tick();
    end
    checks++; if (acc != 3) begin errors++; $display("FAIL b2b accepts got %0d exp 3", acc); end
    b0.in_valid = 1'b0; b0.in_last = 1'b0;
  endtask

  // Output held off for 20 cycles while token B sits at phase 3.
  task automatic test_stall();
    for (int c = 0; c <= 50; c++) begin
      logic [3:0] e_st;
      logic       e_en, e_rdy, e_ov;
      b0.in_valid  = (c == 0 || c == 12);
      b0.in_last   = (c == 12);
      b0.out_ready = !(c >= 16 && c <= 35);
      if (c >= 1 && c <= 12)       e_st = 4'(c - 1);
      else if (c >= 13 && c <= 16) e_st = 4'(c - 13);
      else if (c >= 17 && c <= 36) e_st = 4'd3;
      else if (c >= 37 && c <= 44) e_st = 4'(c - 33);
      else                         e_st = 4'd0;
      e_en  = (c >= 1) && (c <= 48) && !(c >= 16 && c <= 35);
      e_rdy = (c == 0) || (c == 12) || (c >= 44);
      e_ov  = (c >= 16 && c <= 36) || (c == 48);
      #1;
      checks++; if (b0.st !== e_st) begin errors++; $display("FAIL stall st c=%0d got %0d exp %0d", c, b0.st, e_st); end
      checks++; if (b0.clk_en !== e_en) begin errors++; $display("FAIL stall clk_en c=%0d got %b exp %b", c, b0.clk_en, e_en); end
      checks++; if (b0.in_ready !== e_rdy) begin errors++; $display("FAIL stall in_ready c=%0d got %b exp %b", c, b0.in_ready, e_rdy); end
      checks++; if (b0.out_valid !== e_ov) begin errors++; $display("FAIL stall out_valid c=%0d got %b exp %b", c, b0.out_valid, e_ov); end
      checks++; if (b0.out_last !== (c == 48)) begin errors++; $display("FAIL stall out_last c=%0d got %b", c, b0.out_last); end
      tick();
    end
    b0.in_valid = 1'b0; b0.in_last = 1'b0; b0.out_ready = 1'b1;
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_PERF_EN
    checks++; if (sc0 !== 32'd20) begin errors++; $display("FAIL perf stall_cnt got %0d exp 20", sc0); end
`endif
  endtask

  // u1: result of A lands while C is on its final phase with D waiting.
  task automatic test_final_stall();
    int acc = 0;
    for (int c = 0; c <= 60; c++) begin
      b1.in_valid  = (acc < 4);
      b1.in_last   = (acc == 3);
      b1.out_ready = !(c >= 24 && c <= 27);
      #1;
      if (c >= 24 && c <= 27) begin
        checks++; if (b1.st !== 4'd7) begin errors++; $display("FAIL fstall st c=%0d got %0d exp 7", c, b1.st); end
        checks++; if (b1.st_last !== 1'b1) begin errors++; $display("FAIL fstall st_last c=%0d got %b exp 1", c, b1.st_last); end
        checks++; if (b1.in_ready !== 1'b0) begin errors++; $display("FAIL fstall in_ready c=%0d got %b exp 0", c, b1.in_ready); end
        checks++; if (b1.clk_en !== 1'b0) begin errors++; $display("FAIL fstall clk_en c=%0d got %b exp 0", c, b1.clk_en); end
      end
      if (c == 28) begin
        checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL fstall release in_ready got %b exp 1", b1.in_ready); end
        checks++; if (b1.st !== 4'd7) begin errors++; $display("FAIL fstall release st got %0d exp 7", b1.st); end
      end
      if (c == 29) begin
        checks++; if (b1.st !== 4'd0 || b1.st_first !== 1'b1) begin errors++; $display("FAIL fstall wrap st=%0d st_first=%b exp 0/1", b1.st, b1.st_first); end
      end
      checks++; if (b1.out_valid !== ((c >= 24 && c <= 28) || c == 36 || c == 44 || c == 52)) begin errors++; $display("FAIL fstall out_valid c=%0d got %b", c, b1.out_valid); end
      checks++; if (b1.out_last !== (c == 52)) begin errors++; $display("FAIL fstall out_last c=%0d got %b", c, b1.out_last); end
      if (b1.in_valid && b1.in_ready) acc++;
      tick();
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL fstall accepts got %0d exp 4", acc); end
    b1.in_valid = 1'b0; b1.in_last = 1'b0; b1.out_ready = 1'b1;
  endtask

  // u1: reset while C is at phase 7 with tags of A and B in flight.
  task automatic test_reset_midflight();
    int acc = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int c = 0; c < 24; c++) begin
      b1.in_valid = (acc < 3);
      #1;
      if (b1.in_valid && b1.in_ready) acc++;
      tick();
    end
    b1.in_valid = 1'b0;
    #1;
    checks++; if (b1.st !== 4'd7 || b1.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid pre st=%0d out_valid=%b exp 7/1", b1.st, b1.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (b1.st !== 4'd0) begin errors++; $display("FAIL rstmid st got %0d exp 0", b1.st); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid out_valid got %b exp 0", b1.out_valid); end
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid in_ready got %b exp 1", b1.in_ready); end
    checks++; if (b1.clk_en !== 1'b0 || b1.st_last !== 1'b0) begin errors++; $display("FAIL rstmid clk_en=%b st_last=%b exp 0/0", b1.clk_en, b1.st_last); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid spurious out_valid c=%0d got %b", c, b1.out_valid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_final_stall();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlsc_demosaic_vng6_seq.md
Name: dlsc_demosaic_vng6_seq

Overview:
- Phase sequencer that drives the 4-bit st index and the clk_en strobe consumed by the per-state control ROMs and datapath of the VNG6 demosaic engine.
- Accepts one pixel-group token per ready/valid handshake and steps st through 0..STATES-1 once per token.
- Tracks tokens through the engine pipeline and presents out_valid/out_last with downstream backpressure.
- Any output stall freezes the whole engine through clk_en.

Parameters:
- STATES, 12, phases per token; legal range 2..16.
- PIPE, 4, clk_en-qualified cycles from the final phase (st=STATES-1) to the result at the engine output; legal range 1..16.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream token available.
- in_ready  output  1  token accepted when in_valid&&in_ready.
- in_last  input  1  token is last of row; sampled on accept.
- clk_en  output  1  engine/ROM advance strobe (combinational).
- st  output  4  current phase index, valid while running.
- st_first  output  1  st==0 and running.
- st_last  output  1  st==STATES-1 and running.
- out_valid  output  1  engine result valid.
- out_last  output  1  result is last of row.
- out_ready  input  1  downstream accepts result.

Behaviour:
- Reset (async assert, sync-released by the system): FSM=IDLE, st=0, pipeline tags cleared. Outputs at reset: out_valid=0, out_last=0, st_first=0, st_last=0, clk_en=0, in_ready=1.
- stall = out_valid && !out_ready. This is the only backpressure source.
- clk_en = !stall && (running || any tag valid). The pipeline keeps draining while IDLE.
- FSM states: IDLE, RUN.
- IDLE, accept: in_ready = !stall. On accept, go to RUN with st=0, and latch in_last into last_r.
- RUN, advance: on clk_en, st increments.
- RUN, final phase: at st==STATES-1 with clk_en, a tag {valid=1, last=last_r} enters the tag shift register. In the same cycle in_ready = !stall.
  - If in_valid: accept back-to-back, st wraps to 0, stay in RUN, and latch the new last_r.
  - Otherwise: return to IDLE, st=0.
- in_ready is 0 in RUN for all st < STATES-1. Back-to-back tokens therefore run with zero bubble; throughput is 1 token per STATES cycles.
- Tag shift register: PIPE entries, shifts only on clk_en.
  - out_valid/out_last = last entry.
  - An entry is consumed when out_valid&&out_ready; it is cleared if no new tag shifts into it that cycle.
- Latency: the first accept with the output idle gives out_valid exactly STATES+PIPE cycles after the accept cycle, absent stalls.
- Simultaneous events:
  - A stall on the same cycle as st==STATES-1 blocks accept, the st wrap and tag insert together. st holds at STATES-1.
  - out_ready rising releases everything in the following cycle.
- st is held while clk_en=0.
- Reset mid-token discards the token and all in-flight tags; no partial out_valid.
- Widths: st is 4 bits, wrapping at STATES-1, never at 15. Tag register is PIPE×2 bits.

Optional Feature:
- Macro: DLSC_DEMOSAIC_VNG6_SEQ_PERF_EN.
- With the macro: adds output stall_cnt[31:0], which counts cycles with stall && (running || tags valid).
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset only.
- Without the macro: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dlsc_demosaic_vng6_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_RUN);
  - the VNG6_STATES=12 default;
  - the 4-bit phase width constant shared with the ROM.
- One natural sub-module: dlsc_demosaic_vng6_tagpipe, the PIPE-deep clk_en-gated valid/last shift register with output-consume clear.

Test Plan:
- Single token (STATES=12, PIPE=4), out_ready=1:
  - accept at cycle 0 -> st 0..11 on cycles 1..12;
  - st_first at cycle 1, st_last at cycle 12;
  - out_valid for exactly 1 cycle at cycle 16.
- Three back-to-back tokens, in_valid held, last on the third:
  - in_ready pulses every 12 cycles;
  - out_valid at cycles 16, 28, 40;
  - out_last=1 only at cycle 40.
- out_ready=0 while out_valid:
  - clk_en=0, st frozen (e.g. at 5), in_ready=0;
  - on release, st resumes at 6 the next cycle with no token lost.
- Stall coinciding with st==11 while in_valid=1:
  - no accept, st stays 11;
  - the accept occurs on the release cycle.
- Assert rst_n=0 at st=7 with 2 tags in flight:
  - immediately st=0, out_valid=0, in_ready=1;
  - no spurious out_valid afterwards.
- Macro defined, hold out_ready=0 for 20 cycles with a tag pending -> stall_cnt=20.
